// File: rtl/me_pkg.sv
// Shared motion-estimation types and lane packing helpers.
// Used by sad_lane_packer and its abs_diff lane stage.
package me_pkg;

  localparam int ME_LANES   = 8;
  localparam int LANE_CNT_W = 3;
  localparam int OUT_CNT_W  = 4;

  typedef enum logic {
    COLLECT,
    STALL
  } pkr_state_t;

  function automatic int lane_lsb(
    input int idx,
    input int width
  );
    return idx * width;
  endfunction

endpackage

// File: rtl/abs_diff.sv
// Combinational absolute difference of two unsigned pixels.
// Feeds one lane of the SAD packer.
module abs_diff
  import me_pkg::*;
#(
  parameter int PIXEL_BIT_DEPTH = 8
) (
  input  logic [PIXEL_BIT_DEPTH-1:0] a,
  input  logic [PIXEL_BIT_DEPTH-1:0] b,
  output logic [PIXEL_BIT_DEPTH-1:0] d
);

  // larger minus smaller never wraps
  always_comb begin
    d = (a > b) ? (a - b) : (b - a);
  end

endmodule

// File: rtl/sad_lane_packer.sv
// Packs 8 per-pixel differences into the SAD adder-tree lane vector.
// SAD_LANE_PACKER_ABSDIFF_EN selects |cur-ref| lanes, else cur pass-through.
module sad_lane_packer
  import me_pkg::*;
#(
  parameter int ELEMENT_BIT_DEPTH = 14,
  parameter int PIXEL_BIT_DEPTH   = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [PIXEL_BIT_DEPTH-1:0]          cur_pix,
  input  logic [PIXEL_BIT_DEPTH-1:0]          ref_pix,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ELEMENT_BIT_DEPTH*ME_LANES-1:0] addend_array,
  output logic [OUT_CNT_W-1:0]                out_count
);

  localparam int E = ELEMENT_BIT_DEPTH;
  localparam int P = PIXEL_BIT_DEPTH;
  localparam int VW = E * ME_LANES;

  pkr_state_t state_q;
  pkr_state_t state_d;

  logic [LANE_CNT_W-1:0] lane_cnt_q;
  logic [E-1:0]          fill_q [ME_LANES];
  logic [OUT_CNT_W-1:0]  fill_cnt_q;

  logic [P-1:0]         lane_pix;
  logic [E-1:0]         lane_val;
  logic [VW-1:0]        row_vec;
  logic [VW-1:0]        fill_vec;
  logic [OUT_CNT_W-1:0] row_cnt;

  logic accept;
  logic row_done;
  logic can_load;
  logic load_row;
  logic load_fill;
  logic hold_row;

`ifdef SAD_LANE_PACKER_ABSDIFF_EN
  abs_diff #(
    .PIXEL_BIT_DEPTH(P)
  ) u_abs_diff (
    .a(cur_pix),
    .b(ref_pix),
    .d(lane_pix)
  );
`else
  logic unused_ref;
  assign unused_ref = ^ref_pix;
  assign lane_pix   = cur_pix;
`endif

  assign lane_val = {{(E-P){1'b0}}, lane_pix};
  assign in_ready = (state_q == COLLECT);
  assign accept   = in_valid & in_ready;
  assign can_load = !out_valid | out_ready;
  assign row_done = accept &
    (in_last | (lane_cnt_q == LANE_CNT_W'(ME_LANES-1)));
  assign row_cnt  = OUT_CNT_W'(lane_cnt_q) + OUT_CNT_W'(1);

  // completed row: written lanes, current pair, zero padding above
  always_comb begin
    row_vec  = '0;
    fill_vec = '0;
    for (int i = 0; i < ME_LANES; i++) begin
      fill_vec[lane_lsb(i, E) +: E] = fill_q[i];
      if (LANE_CNT_W'(i) < lane_cnt_q)
        row_vec[lane_lsb(i, E) +: E] = fill_q[i];
      else if (LANE_CNT_W'(i) == lane_cnt_q)
        row_vec[lane_lsb(i, E) +: E] = lane_val;
    end
  end

  // state register: STALL means a finished row waits in the fill buffer
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= COLLECT;
    else
      state_q <= state_d;
  end

  // next state and row routing
  always_comb begin
    state_d   = state_q;
    load_row  = 1'b0;
    load_fill = 1'b0;
    hold_row  = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (row_done) begin
          if (can_load) begin
            load_row = 1'b1;
          end else begin
            hold_row = 1'b1;
            state_d  = STALL;
          end
        end
      end
      STALL: begin
        if (out_ready) begin
          load_fill = 1'b1;
          state_d   = COLLECT;
        end
      end
    endcase
  end

  // fill buffer and lane counter
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt_q <= '0;
      fill_cnt_q <= '0;
      for (int i = 0; i < ME_LANES; i++)
        fill_q[i] <= '0;
    end else begin
      if (accept) begin
        if (row_done)
          lane_cnt_q <= '0;
        else
          lane_cnt_q <= lane_cnt_q + LANE_CNT_W'(1);
      end
      if (hold_row)
        fill_cnt_q <= row_cnt;
      for (int i = 0; i < ME_LANES; i++) begin
        if (hold_row)
          fill_q[i] <= row_vec[lane_lsb(i, E) +: E];
        else if (accept && !row_done &&
                 lane_cnt_q == LANE_CNT_W'(i))
          fill_q[i] <= lane_val;
      end
    end
  end

  // output register, held stable until transferred
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      addend_array <= '0;
      out_count    <= '0;
    end else if (load_row) begin
      out_valid    <= 1'b1;
      addend_array <= row_vec;
      out_count    <= row_cnt;
    end else if (load_fill) begin
      out_valid    <= 1'b1;
      addend_array <= fill_vec;
      out_count    <= fill_cnt_q;
    end else if (out_valid && out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sad_lane_packer.sv
// Self-checking bench for sad_lane_packer against a row-queue model.
// Honours SAD_LANE_PACKER_ABSDIFF_EN for expected lane values.
module tb_sad_lane_packer;
  import me_pkg::*;

  localparam int E  = 14;
  localparam int P  = 8;
  localparam int VW = E * ME_LANES;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [P-1:0]  cur_pix;
  logic [P-1:0]  ref_pix;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] addend_array;
  logic [3:0]    out_count;

  sad_lane_packer #(
    .ELEMENT_BIT_DEPTH(E),
    .PIXEL_BIT_DEPTH(P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .cur_pix(cur_pix),
    .ref_pix(ref_pix),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .addend_array(addend_array),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] vec;
    logic [3:0]    cnt;
  } row_t;

  row_t exp_q[$];
  int   cur_row[$];
  int   checks = 0;
  int   errors = 0;
  logic m_acc;
  logic m_xfer;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int lane_of(input int c, input int r);
`ifdef SAD_LANE_PACKER_ABSDIFF_EN
    return (c > r) ? c - r : r - c;
`else
    return c + 0 * r;
`endif
  endfunction

  function automatic int lane_at(input logic [VW-1:0] v, input int i);
    return int'(v[i*E +: E]);
  endfunction

  task automatic check_outputs();
    chk("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
    chk("in_ready", 128'(in_ready), 128'(exp_q.size() < 2));
    if (exp_q.size() > 0) begin
      chk("addend", 128'(addend_array), 128'(exp_q[0].vec));
      chk("count", 128'(out_count), 128'(exp_q[0].cnt));
    end
  endtask

  task automatic model_edge();
    row_t r;
    if (m_xfer)
      void'(exp_q.pop_front());
    if (m_acc) begin
      cur_row.push_back(lane_of(int'(cur_pix), int'(ref_pix)));
      if (in_last || cur_row.size() == ME_LANES) begin
        r.vec = '0;
        foreach (cur_row[i])
          r.vec[i*E +: E] = E'(cur_row[i]);
        r.cnt = 4'(cur_row.size());
        exp_q.push_back(r);
        cur_row.delete();
      end
    end
  endtask

  task automatic step(input logic iv, input int c, input int r,
                      input logic l, input logic ordy);
    @(negedge clk);
    check_outputs();
    in_valid  = iv;
    cur_pix   = P'(c);
    ref_pix   = P'(r);
    in_last   = l;
    out_ready = ordy;
    m_acc  = iv && (exp_q.size() < 2);
    m_xfer = ordy && (exp_q.size() > 0);
    @(posedge clk);
    model_edge();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_last   = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_addend", 128'(addend_array), 128'(0));
    chk("rst_count", 128'(out_count), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    exp_q.delete();
    cur_row.delete();
    rst = 1'b0;
  endtask

  int fc [8] = '{10, 3, 255, 0, 7, 100, 50, 1};
  int fr [8] = '{3, 10, 0, 255, 7, 50, 100, 0};
`ifdef SAD_LANE_PACKER_ABSDIFF_EN
  int fexp [8] = '{7, 7, 255, 255, 0, 50, 50, 1};
  int fsum = 625;
  int pexp [3] = '{3, 3, 8};
  int nexp = 3;
  int mexp = 50;
`else
  int fexp [8] = '{10, 3, 255, 0, 7, 100, 50, 1};
  int fsum = 426;
  int pexp [3] = '{5, 2, 9};
  int nexp = 4;
  int mexp = 200;
`endif

  initial begin
    int sum;
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b0;
    cur_pix = '0;
    ref_pix = '0;
    do_reset();

    // full row with consumer ready
    for (int i = 0; i < 8; i++)
      step(1'b1, fc[i], fr[i], 1'b0, 1'b1);
    #1;
    chk("full_valid", 128'(out_valid), 128'(1));
    chk("full_count", 128'(out_count), 128'(8));
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      chk("full_lane", 128'(lane_at(addend_array, i)), 128'(fexp[i]));
      sum += lane_at(addend_array, i);
    end
    chk("full_sum", 128'(sum), 128'(fsum));

    // partial row closed by in_last
    step(1'b1, 5, 2, 1'b0, 1'b1);
    step(1'b1, 2, 5, 1'b0, 1'b1);
    step(1'b1, 9, 1, 1'b1, 1'b1);
    #1;
    chk("part_count", 128'(out_count), 128'(3));
    for (int i = 0; i < 8; i++)
      chk("part_lane", 128'(lane_at(addend_array, i)),
          128'((i < 3) ? pexp[i] : 0));
    step(1'b1, 4, 1, 1'b1, 1'b1);
    #1;
    chk("next_lane0", 128'(lane_at(addend_array, 0)), 128'(nexp));
    chk("next_count", 128'(out_count), 128'(1));

    // pass-through vs absdiff lane value
    step(1'b1, 200, 250, 1'b1, 1'b1);
    #1;
    chk("macro_lane", 128'(lane_at(addend_array, 0)), 128'(mexp));
    step(1'b0, 0, 0, 1'b0, 1'b1);

    // backpressure: 16 pairs with consumer stalled
    for (int i = 0; i < 16; i++)
      step(1'b1, $urandom_range(0, 255), $urandom_range(0, 255),
           1'b0, 1'b0);
    #1;
    chk("bp_in_ready", 128'(in_ready), 128'(0));
    chk("bp_out_valid", 128'(out_valid), 128'(1));
    step(1'b1, 1, 2, 1'b0, 1'b1);
    #1;
    chk("bp_row2_valid", 128'(out_valid), 128'(1));
    chk("bp_ready_back", 128'(in_ready), 128'(1));
    step(1'b0, 0, 0, 1'b0, 1'b1);
    #1;
    chk("bp_drained", 128'(out_valid), 128'(0));
    do_reset();

    // row 2 completes in the same cycle row 1 departs
    for (int i = 0; i < 15; i++)
      step(1'b1, $urandom_range(0, 255), $urandom_range(0, 255),
           1'b0, 1'b0);
    step(1'b1, 17, 3, 1'b0, 1'b1);
    #1;
    chk("sim_valid", 128'(out_valid), 128'(1));
    chk("sim_count", 128'(out_count), 128'(8));
    chk("sim_lane7", 128'(lane_at(addend_array, 7)),
        128'(lane_of(17, 3)));

    // reset while stalled, then a fresh row from lane 0
    for (int i = 0; i < 8; i++)
      step(1'b1, $urandom_range(0, 255), $urandom_range(0, 255),
           1'b0, 1'b0);
    #1;
    chk("pre_rst_stall", 128'(in_ready), 128'(0));
    do_reset();
    step(1'b1, 60, 20, 1'b1, 1'b1);
    #1;
    chk("post_rst_lane0", 128'(lane_at(addend_array, 0)),
        128'(lane_of(60, 20)));
    chk("post_rst_count", 128'(out_count), 128'(1));

    // randomized traffic
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 4) < 3);
    for (int n = 0; n < 4; n++)
      step(1'b0, 0, 0, 1'b0, 1'b1);
    @(negedge clk);
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sad_lane_packer.md
# sad_lane_packer

Streaming front end for the 8-input adder tree in the motion-estimation SAD datapath. The block accepts one pixel pair per cycle over a valid/ready handshake and computes |cur − ref| per pair. It packs eight consecutive results into the flat lane vector the adder tree consumes, then presents that vector over a second valid/ready handshake. A two-stage fill/output buffer lets collection of the next row overlap a stalled downstream.

## Interface
- ELEMENT_BIT_DEPTH, 14, width of one packed lane; must be ≥ PIXEL_BIT_DEPTH+3 so the 8-lane sum cannot overflow
- PIXEL_BIT_DEPTH, 8, width of cur_pix/ref_pix
- clk  input  1  clock, all logic rising-edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  pixel pair valid
- in_ready  output  1  block can accept a pair this cycle
- cur_pix  input  PIXEL_BIT_DEPTH  current-block pixel
- ref_pix  input  PIXEL_BIT_DEPTH  reference-block pixel
- in_last  input  1  accepted pair closes the row early (partial vector)
- out_valid  output  1  addend_array valid
- out_ready  input  1  consumer takes the vector this cycle
- addend_array  output  ELEMENT_BIT_DEPTH*8  lane i at [(i+1)*ELEMENT_BIT_DEPTH-1 : i*ELEMENT_BIT_DEPTH]
- out_count  output  4  number of real lanes in addend_array, 1..8

## Operation
- Accept = in_valid & in_ready. Transfer = out_valid & out_ready.
- Each accept writes lane[lane_cnt] = zero-extended |cur_pix − ref_pix| into the fill buffer and increments lane_cnt (0..7). The first pair of a row goes to lane 0.
- A row is complete when lane 7 is accepted, or when any lane is accepted with in_last=1.
- On completion:
  - Unwritten lanes are zero.
  - out_count = lanes written.
  - lane_cnt returns to 0.
- Completed row handling:
  - If the output register is empty, or is transferred in the same cycle, the row moves to the output register at the next edge.
  - Otherwise the row stays in the fill buffer with fill_full=1.
- in_ready = !fill_full. While fill_full=1 no pairs are accepted. The row moves to the output register on the cycle after transfer, and fill_full clears then.
- States:
  - COLLECT: fill_full=0.
  - STALL: fill_full=1, entered only when a row completes while the output is held.
  - STALL → COLLECT on transfer.
- Output register contents are stable while out_valid=1 and out_ready=0.
- Unwritten lanes of the fill buffer carry no meaning. Only the zero padding at completion is specified.

## Timing
- Latency: row completes at edge t → out_valid=1 after edge t+1 (one cycle after the final accept).
- Back-to-back rows with out_ready held at 1: one pair accepted every cycle, one vector every 8 cycles, no bubbles.
- Simultaneous completion and transfer: the new row replaces the departing vector with no gap. out_valid stays 1.
- in_last on lane 7: treated as an ordinary full row, out_count=8.
- in_last on a pair that is not accepted: ignored.
- Reset (including mid-row or mid-stall):
  - out_valid=0, addend_array=0, out_count=0.
  - lane_cnt=0, fill_full=0, in_ready=1 after the reset edge.
  - Partial and pending rows are discarded.

## Configuration
- SAD_LANE_PACKER_ABSDIFF_EN
  - Defined: lane = |cur_pix − ref_pix|.
  - Undefined: lane = cur_pix zero-extended, ref_pix ignored. This is the pass-through used when an upstream stage already produced differences.
- Handshake, timing and port list are identical in both builds.

## Structure
- Shared package me_pkg:
  - ME_LANES=8.
  - Lane-counter width (3).
  - out_count width (4).
  - Lane slice helper for the packing convention.
- One sub-module: abs_diff, combinational, PIXEL_BIT_DEPTH in → PIXEL_BIT_DEPTH out. It is instantiated only when SAD_LANE_PACKER_ABSDIFF_EN is defined.

## Test plan
- Full row, out_ready=1:
  - Stimulus: pairs (cur,ref) = (10,3), (3,10), (255,0), (0,255), (7,7), (100,50), (50,100), (1,0).
  - Required: out_valid one cycle after the 8th accept; lanes 7,7,255,255,0,50,50,1; out_count=8. Downstream tree sum is 625.
- Partial row:
  - Stimulus: three pairs (5,2), (2,5), (9,1), with in_last on the third.
  - Required: lanes 3,3,8,0,0,0,0,0; out_count=3. The next pair lands in lane 0.
- Backpressure:
  - Stimulus: out_ready=0; send 16 pairs.
  - Required: first vector held stable; second row fills and in_ready drops after its 8th accept. Raising out_ready for one cycle yields vector 1, then vector 2 on the next cycle, and in_ready returns to 1.
- Simultaneous event:
  - Stimulus: 8th accept of row 2 in the same cycle as the transfer of row 1.
  - Required: out_valid stays 1 and row 2 is presented on the next cycle with no gap.
- Reset mid-stall:
  - Stimulus: assert rst with out_valid=1 and fill_full=1.
  - Required: next cycle out_valid=0, addend_array=0, out_count=0, in_ready=1. A fresh row starts at lane 0.
- Macro off:
  - Stimulus: pair (200,250).
  - Required: lane value 200.
